// File: rtl/rv32_pkg.sv
// Shared RV32 core constants: register file geometry
// and write-back select encoding.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_PC   = 2'b10;
  localparam logic [1:0] WB_SEL_ZERO = 2'b11;

endpackage

// File: rtl/rv32_rf_read_port.sv
// One combinational register-file read port:
// x0 check, range check and write-back bypass.
module rv32_rf_read_port
  import rv32_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int NREG_P    = NREG,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                         en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [NREG_P-1:0][XLEN_P-1:0] regs,
  input  logic                         wr_hit,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [XLEN_P-1:0]            wr_data,
  output logic [XLEN_P-1:0]            data
);

  logic [XLEN_P-1:0] stored;

  // Out-of-range addresses match no entry and read 0.
  always_comb begin
    stored = '0;
    for (int i = 0; i < NREG_P; i++) begin
      if (int'(addr) == i) begin
        stored = regs[i];
      end
    end
  end

  always_comb begin
    data = '0;
    if (en && (addr != '0)) begin
      data = stored;
      if (BYPASS_EN && wr_hit &&
          (addr == wr_addr)) begin
        data = wr_data;
      end
    end
  end

endmodule

// File: rtl/rv32_reg_file.sv
// Integer register file x0..x31 with two bypassed
// read ports, a debug port and a commit counter.
module rv32_reg_file
  import rv32_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int NREG_P    = NREG,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              ip_clk,
  input  logic              ip_rst_n,
  input  logic              ip_RegWrite,
  input  logic [ADDR_W-1:0] ip_rd_addr,
  input  logic [XLEN_P-1:0] ip_Writeback_data,
  input  logic [ADDR_W-1:0] ip_rs1_addr,
  input  logic [ADDR_W-1:0] ip_rs2_addr,
  output logic [XLEN_P-1:0] op_rs1_data,
  output logic [XLEN_P-1:0] op_rs2_data,
  input  logic [ADDR_W-1:0] ip_dbg_addr,
  output logic [XLEN_P-1:0] op_dbg_data,
  output logic [31:0]       op_wr_count
);

  logic [NREG_P-1:0][XLEN_P-1:0] regs_q;
  logic [NREG_P-1:0][XLEN_P-1:0] regs_d;
  logic [31:0]                   wr_count_q;
  logic [31:0]                   wr_count_d;
  logic [ADDR_W:0]               rd_ext;
  logic                          wr_hit;

  assign rd_ext = {1'b0, ip_rd_addr};

  assign wr_hit = ip_RegWrite &&
                  (ip_rd_addr != ADDR_W'(REG_ZERO)) &&
                  (rd_ext < (ADDR_W+1)'(NREG_P));

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_hit) begin
      for (int i = 1; i < NREG_P; i++) begin
        if (int'(ip_rd_addr) == i) begin
          regs_d[i] = ip_Writeback_data;
        end
      end
      wr_count_d = wr_count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      regs_q     <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  rv32_rf_read_port #(
    .XLEN_P   (XLEN_P),
    .NREG_P   (NREG_P),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(BYPASS_EN)
  ) u_rs1 (
    .en     (ip_rst_n),
    .addr   (ip_rs1_addr),
    .regs   (regs_q),
    .wr_hit (wr_hit),
    .wr_addr(ip_rd_addr),
    .wr_data(ip_Writeback_data),
    .data   (op_rs1_data)
  );

  rv32_rf_read_port #(
    .XLEN_P   (XLEN_P),
    .NREG_P   (NREG_P),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(BYPASS_EN)
  ) u_rs2 (
    .en     (ip_rst_n),
    .addr   (ip_rs2_addr),
    .regs   (regs_q),
    .wr_hit (wr_hit),
    .wr_addr(ip_rd_addr),
    .wr_data(ip_Writeback_data),
    .data   (op_rs2_data)
  );

  // Debug sees committed state only, never the bypass.
  always_comb begin
    op_dbg_data = '0;
    for (int i = 0; i < NREG_P; i++) begin
      if (ip_rst_n && (int'(ip_dbg_addr) == i)) begin
        op_dbg_data = regs_q[i];
      end
    end
  end

  assign op_wr_count = wr_count_q;

endmodule
